// File: rtl/fir_xifu_wb_queue.sv
// Write-back queue of the FIR XIFU coprocessor: in-order retirement of XFIRLW/SW/DOTP
// towards the XIF result interface and coprocessor register file, with kill flushing.
module fir_xifu_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ex_valid_i,
  output logic                       ex_ready_o,
  input  logic [1:0]                 ex_instr_i,
  input  logic [ID_W-1:0]            ex_id_i,
  input  logic [4:0]                 ex_rd_i,
  input  logic [4:0]                 ex_rs1_i,
  input  logic [DATA_W-1:0]          ex_result_i,
  input  logic                       mem_result_valid_i,
  input  logic [ID_W-1:0]            mem_result_id_i,
  input  logic [DATA_W-1:0]          mem_result_rdata_i,
  input  logic [(2**ID_W)-1:0]       commit_i,
  input  logic [(2**ID_W)-1:0]       kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_W-1:0]            result_id_o,
  output logic [DATA_W-1:0]          result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic                       rf_write_o,
  output logic [4:0]                 rf_rd_o,
  output logic [DATA_W-1:0]          rf_data_o,
  output logic [(2**ID_W)-1:0]       clear_o,
  output logic                       kill_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    INSTR_INVALID = 2'd0,
    INSTR_LW      = 2'd1,
    INSTR_SW      = 2'd2,
    INSTR_DOTP    = 2'd3
  } instr_e;

  typedef struct packed {
    instr_e              instr;
    logic [ID_W-1:0]     id;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [DATA_W-1:0]   result;
    logic                done;
    logic [DATA_W-1:0]   rdata;
  } entry_t;

  entry_t            entries_q [DEPTH];
  entry_t            entries_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  instr_e            ex_instr;
  logic [PTR_W-1:0]  slot [DEPTH];
  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  mem_match;
  logic [DEPTH-1:0]  kill_match;
  logic              mem_any;
  logic [PTR_W-1:0]  mem_off;
  logic [PTR_W-1:0]  kill_off;
  entry_t            head;
  logic              head_valid;
  logic              head_mem;
  logic              head_done;
  logic              retire;
  logic              enq;
  logic              enq_mem_hit;

  assign ex_instr = instr_e'(ex_instr_i);

  // Per-age view of the buffer: offset 0 is the head (oldest entry).
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot[i]       = head_q + PTR_W'(i);
      live[i]       = CNT_W'(i) < count_q;
      mem_match[i]  = live[i] & mem_result_valid_i
                    & (entries_q[slot[i]].id == mem_result_id_i)
                    & ~entries_q[slot[i]].done;
      kill_match[i] = live[i] & kill_i[entries_q[slot[i]].id];
    end
  end

  always_comb begin
    mem_any  = |mem_match;
    kill_o   = |kill_match;
    mem_off  = '0;
    kill_off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_match[DEPTH-1-i])  mem_off  = PTR_W'(DEPTH-1-i);
      if (kill_match[DEPTH-1-i]) kill_off = PTR_W'(DEPTH-1-i);
    end
  end

  always_comb begin
    head        = entries_q[head_q];
    head_valid  = count_q != '0;
    head_mem    = mem_match[0];
    head_done   = head.done | head_mem;

    result_valid_o = head_valid & head_done & commit_i[head.id] & ~kill_o;
    retire         = result_valid_o & result_ready_i;

    ex_ready_o  = (count_q < CNT_W'(DEPTH)) & ~kill_o;
    enq         = ex_valid_i & ex_ready_o & (ex_instr != INSTR_INVALID);
    // A memory result may belong to the instruction being enqueued right now.
    enq_mem_hit = enq & mem_result_valid_i & ~mem_any & (ex_instr != INSTR_DOTP)
                & (ex_id_i == mem_result_id_i);

    result_id_o   = '0;
    result_data_o = '0;
    result_rd_o   = '0;
    result_we_o   = 1'b0;
    if (head_valid) begin
      result_id_o   = head.id;
      result_data_o = head.result;
      result_rd_o   = head.rs1;
      result_we_o   = (head.instr == INSTR_LW) | (head.instr == INSTR_SW);
    end

    rf_write_o = retire & ((head.instr == INSTR_LW) | (head.instr == INSTR_DOTP));
    rf_rd_o    = '0;
    rf_data_o  = '0;
    if (rf_write_o) begin
      rf_rd_o = head.rd;
      if (head.instr == INSTR_DOTP) rf_data_o = head.result;
      else                          rf_data_o = head_mem ? mem_result_rdata_i : head.rdata;
    end

    clear_o = '0;
    if (kill_o) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live[i] && (PTR_W'(i) >= kill_off)) clear_o[entries_q[slot[i]].id] = 1'b1;
      end
    end else if (retire) begin
      clear_o[head.id] = 1'b1;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    err_d     = err_q;

    if (mem_result_valid_i && !mem_any && !enq_mem_hit) err_d = 1'b1;

    if (kill_o) begin
      // Results for entries older than the flush point are still recorded.
      if (mem_any && (mem_off < kill_off)) begin
        entries_d[head_q + mem_off].done  = 1'b1;
        entries_d[head_q + mem_off].rdata = mem_result_rdata_i;
      end
      tail_d  = head_q + kill_off;
      count_d = CNT_W'(kill_off);
    end else begin
      if (mem_any) begin
        entries_d[head_q + mem_off].done  = 1'b1;
        entries_d[head_q + mem_off].rdata = mem_result_rdata_i;
      end
      if (enq) begin
        entries_d[tail_q] = '{instr:  ex_instr,
                              id:     ex_id_i,
                              rd:     ex_rd_i,
                              rs1:    ex_rs1_i,
                              result: ex_result_i,
                              done:   (ex_instr == INSTR_DOTP) | enq_mem_hit,
                              rdata:  enq_mem_hit ? mem_result_rdata_i : '0};
        tail_d = tail_q + 1'b1;
      end
      if (retire) head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(enq) - CNT_W'(retire);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign occupancy_o = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fir_xifu_wb_queue.sv
// Bench for fir_xifu_wb_queue: directed scenarios then random traffic, all outputs
// compared each cycle against a queue-based reference model.
module tb_fir_xifu_wb_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid;
  logic        ex_ready_o;
  logic [1:0]  ex_instr;
  logic [3:0]  ex_id;
  logic [4:0]  ex_rd, ex_rs1;
  logic [31:0] ex_result;
  logic        mem_valid;
  logic [3:0]  mem_id;
  logic [31:0] mem_rdata;
  logic [15:0] commit, kill;
  logic        result_valid_o, res_ready;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o, rf_write_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic [15:0] clear_o;
  logic        kill_o;
  logic [2:0]  occupancy_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          instr;
    int          id;
    int          rd;
    int          rs1;
    logic [31:0] result;
    bit          done;
    logic [31:0] rdata;
  } m_t;

  m_t mq[$];
  bit err_m;
  bit kill_e, ready_e, enq_e, enq_hit_e, ret_e;
  int kidx, midx;

  always #5 clk = ~clk;

  fir_xifu_wb_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready_o), .ex_instr_i(ex_instr),
    .ex_id_i(ex_id), .ex_rd_i(ex_rd), .ex_rs1_i(ex_rs1), .ex_result_i(ex_result),
    .mem_result_valid_i(mem_valid), .mem_result_id_i(mem_id), .mem_result_rdata_i(mem_rdata),
    .commit_i(commit), .kill_i(kill),
    .result_valid_o(result_valid_o), .result_ready_i(res_ready), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .rf_write_o(rf_write_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
    .clear_o(clear_o), .kill_o(kill_o), .occupancy_o(occupancy_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_instr = 2'd0; ex_id = '0; ex_rd = '0; ex_rs1 = '0; ex_result = '0;
    mem_valid = 1'b0; mem_id = '0; mem_rdata = '0;
  endtask

  // Called at a falling edge after inputs are set; compares all outputs with the model.
  task automatic settle_check();
    m_t h;
    bit hv, hdone, rv_e, rfw_e;
    logic [31:0] rfd_e;
    logic [15:0] clr_e;
    #1;
    kill_e = 0;
    kidx = mq.size();
    foreach (mq[i]) if (!kill_e && kill[mq[i].id]) begin kill_e = 1; kidx = i; end
    ready_e = (mq.size() < DEPTH) && !kill_e;
    enq_e = ex_valid && ready_e && (ex_instr != 2'd0);
    midx = -1;
    if (mem_valid) foreach (mq[i]) if (midx < 0 && mq[i].id == mem_id && !mq[i].done) midx = i;
    enq_hit_e = enq_e && mem_valid && (midx < 0) && (ex_instr != 2'd3) && (ex_id == mem_id);
    hv = mq.size() > 0;
    h = '{default: 0};
    if (hv) h = mq[0];
    hdone = hv && (h.done || midx == 0);
    rv_e = hv && hdone && commit[h.id] && !kill_e;
    ret_e = rv_e && res_ready;
    rfw_e = ret_e && (h.instr == 1 || h.instr == 3);
    rfd_e = '0;
    if (rfw_e) rfd_e = (h.instr == 3) ? h.result : ((midx == 0) ? mem_rdata : h.rdata);
    clr_e = '0;
    if (kill_e) begin
      for (int i = kidx; i < mq.size(); i++) clr_e[mq[i].id] = 1'b1;
    end else if (ret_e) begin
      clr_e[h.id] = 1'b1;
    end
    chk("ex_ready", ex_ready_o, ready_e);
    chk("kill", kill_o, kill_e);
    chk("clear", clear_o, clr_e);
    chk("result_valid", result_valid_o, rv_e);
    chk("result_id", result_id_o, hv ? h.id : 0);
    chk("result_data", result_data_o, hv ? h.result : 32'h0);
    chk("result_rd", result_rd_o, hv ? h.rs1 : 0);
    chk("result_we", result_we_o, hv && (h.instr == 1 || h.instr == 2));
    chk("rf_write", rf_write_o, rfw_e);
    chk("rf_rd", rf_rd_o, rfw_e ? h.rd : 0);
    chk("rf_data", rf_data_o, rfd_e);
    chk("occupancy", occupancy_o, mq.size());
    chk("err", err_o, err_m);
  endtask

  task automatic tick();
    m_t t;
    @(posedge clk);
    if (mem_valid && midx < 0 && !enq_hit_e) err_m = 1;
    if (kill_e) begin
      if (midx >= 0 && midx < kidx) begin
        t = mq[midx]; t.done = 1; t.rdata = mem_rdata; mq[midx] = t;
      end
      while (mq.size() > kidx) void'(mq.pop_back());
    end else begin
      if (midx >= 0) begin
        t = mq[midx]; t.done = 1; t.rdata = mem_rdata; mq[midx] = t;
      end
      if (enq_e) begin
        t.instr = ex_instr; t.id = ex_id; t.rd = ex_rd; t.rs1 = ex_rs1; t.result = ex_result;
        t.done = (ex_instr == 2'd3) || enq_hit_e;
        t.rdata = enq_hit_e ? mem_rdata : 32'h0;
        mq.push_back(t);
      end
      if (ret_e) void'(mq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle_check();
    tick();
  endtask

  task automatic enq_instr(input logic [1:0] ins, input logic [3:0] id, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [31:0] res);
    ex_valid = 1'b1; ex_instr = ins; ex_id = id; ex_rd = rd; ex_rs1 = rs1; ex_result = res;
    cyc();
    idle();
  endtask

  initial begin
    int sent;
    idle();
    commit = '0; kill = '0; res_ready = 1'b0; err_m = 0;
    #3;
    chk("rst_ex_ready", ex_ready_o, 1);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_occupancy", occupancy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_kill", kill_o, 0);
    chk("rst_clear", clear_o, 0);
    chk("rst_rf_write", rf_write_o, 0);
    chk("rst_rf_data", rf_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // DOTP retires the cycle after enqueue
    commit = 16'h0008; res_ready = 1'b1;
    enq_instr(2'd3, 4'd3, 5'd10, 5'd0, 32'h1234);
    settle_check();
    chk("tp1_result_valid", result_valid_o, 1);
    chk("tp1_rf_write", rf_write_o, 1);
    chk("tp1_rf_data", rf_data_o, 32'h1234);
    chk("tp1_clear", clear_o, 16'h0008);
    chk("tp1_occ_before", occupancy_o, 1);
    tick();
    settle_check();
    chk("tp1_occ_after", occupancy_o, 0);
    tick();

    // LW retires in its mem-result cycle with bypassed rdata
    commit = 16'h0020;
    enq_instr(2'd1, 4'd5, 5'd7, 5'd2, 32'h0000_1004);
    settle_check();
    chk("tp2_wait", result_valid_o, 0);
    tick();
    mem_valid = 1'b1; mem_id = 4'd5; mem_rdata = 32'hCAFE_BABE;
    settle_check();
    chk("tp2_result_valid", result_valid_o, 1);
    chk("tp2_rf_data", rf_data_o, 32'hCAFE_BABE);
    chk("tp2_rf_rd", rf_rd_o, 7);
    chk("tp2_we", result_we_o, 1);
    chk("tp2_result_data", result_data_o, 32'h0000_1004);
    tick();
    idle();

    // Fill with SWs, back-pressure, single retire, then drain with wrap-around
    commit = '1; res_ready = 1'b0; sent = 0;
    for (int c = 0; c < 6; c++) begin
      ex_valid = 1'b1; ex_instr = 2'd2; ex_id = 4'(sent); ex_rs1 = 5'(sent); ex_result = 32'h2000 + sent;
      settle_check();
      if (enq_e) sent++;
      tick();
    end
    settle_check();
    chk("tp3_full_ready", ex_ready_o, 0);
    chk("tp3_full_occ", occupancy_o, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_id = 4'(k); mem_rdata = 32'h0;
      cyc();
    end
    mem_valid = 1'b0;
    res_ready = 1'b1;
    settle_check();
    chk("tp3_retire_valid", result_valid_o, 1);
    chk("tp3_retire_ready", ex_ready_o, 0);
    chk("tp3_sw_no_rf", rf_write_o, 0);
    tick();
    res_ready = 1'b0;
    settle_check();
    chk("tp3_ready_rise", ex_ready_o, 1);
    if (enq_e) sent++;
    tick();
    res_ready = 1'b1;
    for (int c = 0; c < 60 && (sent < 10 || mq.size() > 0); c++) begin
      ex_valid = (sent < 10); ex_instr = 2'd2; ex_id = 4'(sent); ex_result = 32'h2000 + sent;
      mem_valid = 1'b0;
      foreach (mq[i]) if (!mem_valid && !mq[i].done) begin mem_valid = 1'b1; mem_id = 4'(mq[i].id); end
      settle_check();
      if (enq_e) sent++;
      tick();
    end
    idle();
    chk("tp3_sent", sent, 10);
    chk("tp3_drained", occupancy_o, 0);

    // Kill of the middle entry flushes it and everything younger
    commit = '0; res_ready = 1'b1;
    enq_instr(2'd3, 4'd1, 5'd11, 5'd0, 32'h0000_0111);
    enq_instr(2'd3, 4'd2, 5'd12, 5'd0, 32'h0000_0222);
    enq_instr(2'd3, 4'd3, 5'd13, 5'd0, 32'h0000_0333);
    kill = 16'h0004;
    settle_check();
    chk("tp4_kill", kill_o, 1);
    chk("tp4_clear", clear_o, 16'h000C);
    chk("tp4_no_rf", rf_write_o, 0);
    chk("tp4_occ_before", occupancy_o, 3);
    tick();
    kill = '0;
    settle_check();
    chk("tp4_kill_drop", kill_o, 0);
    chk("tp4_occ_after", occupancy_o, 1);
    tick();
    commit = 16'h0002;
    settle_check();
    chk("tp4_retire_id", result_id_o, 1);
    chk("tp4_retire_rf", rf_write_o, 1);
    tick();
    commit = '0;

    // Unmatched mem result sets the sticky error flag only
    enq_instr(2'd3, 4'd4, 5'd14, 5'd0, 32'h0000_0444);
    mem_valid = 1'b1; mem_id = 4'd9; mem_rdata = 32'hDEAD_0009;
    cyc();
    idle();
    settle_check();
    chk("tp5_err", err_o, 1);
    chk("tp5_occ", occupancy_o, 1);
    tick();
    commit = 16'h0010;
    cyc();
    commit = '0;
    cyc();

    // Commit arrives late; rdata comes from the stored entry
    enq_instr(2'd1, 4'd6, 5'd9, 5'd4, 32'h0000_3000);
    mem_valid = 1'b1; mem_id = 4'd6; mem_rdata = 32'h5A5A_0F0F;
    cyc();
    idle();
    for (int c = 0; c < 5; c++) begin
      settle_check();
      chk("tp6_hold", result_valid_o, 0);
      tick();
    end
    commit = 16'h0040;
    settle_check();
    chk("tp6_valid", result_valid_o, 1);
    chk("tp6_rf_data", rf_data_o, 32'h5A5A_0F0F);
    tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      ex_valid = ($urandom % 3) != 0;
      ex_instr = 2'($urandom);
      ex_id = 4'($urandom); ex_rd = 5'($urandom); ex_rs1 = 5'($urandom); ex_result = $urandom;
      mem_valid = ($urandom % 3) == 0;
      if (mq.size() > 0 && ($urandom % 5) != 0) mem_id = 4'(mq[$urandom % mq.size()].id);
      else mem_id = 4'($urandom);
      mem_rdata = $urandom;
      commit = 16'($urandom | $urandom);
      kill = (($urandom % 25) == 0) ? (16'h0001 << ($urandom % 16)) : 16'h0000;
      res_ready = ($urandom % 4) != 0;
      cyc();
    end

    // Asynchronous reset in the middle of traffic
    rst_n = 1'b0;
    #1;
    chk("mrst_occ", occupancy_o, 0);
    chk("mrst_valid", result_valid_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_ready", ex_ready_o, 1);
    mq.delete();
    err_m = 0;
    idle();
    kill = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ex_valid = ($urandom % 2) != 0;
      ex_instr = 2'($urandom);
      ex_id = 4'($urandom); ex_rd = 5'($urandom); ex_rs1 = 5'($urandom); ex_result = $urandom;
      mem_valid = ($urandom % 3) == 0;
      if (mq.size() > 0) mem_id = 4'(mq[$urandom % mq.size()].id);
      else mem_id = 4'($urandom);
      mem_rdata = $urandom;
      commit = 16'($urandom | $urandom);
      res_ready = ($urandom % 3) != 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_xifu_wb_queue.md
# fir_xifu_wb_queue

Parametrised write-back stage of the FIR XIFU coprocessor: a DEPTH-entry in-order queue between EX and the CV32E40X XIF result/mem_result interfaces and the coprocessor register file. It holds several in-flight XFIRLW/XFIRSW/XFIRDOTP instructions. It matches out-of-band memory results to entries by ID and retires the oldest entry once it is committed, its data is complete and the core accepts the result. It handles scoreboard kills by flushing the queue.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2).
- ID_W, 4: XIF instruction ID width; NB_ID = 2**ID_W.
- DATA_W, 32: data width.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  EX offers an instruction.
- ex_ready_o  out  1  queue accepts it.
- ex_instr_i  in  2  0 INVALID, 1 XFIRLW, 2 XFIRSW, 3 XFIRDOTP.
- ex_id_i  in  ID_W  instruction ID.
- ex_rd_i, ex_rs1_i  in  5 each  destination / base-address register.
- ex_result_i  in  DATA_W  DOTP result or post-incremented address.
- mem_result_valid_i  in  1  memory result strobe.
- mem_result_id_i  in  ID_W  its ID.
- mem_result_rdata_i  in  DATA_W  load data.
- commit_i, kill_i  in  NB_ID  scoreboard commit/kill bit per ID.
- result_valid_o  out  1  XIF result valid.
- result_ready_i  in  1  core accepts the result.
- result_id_o  out  ID_W  head ID.
- result_data_o  out  DATA_W  head ex_result.
- result_rd_o  out  5  head rs1.
- result_we_o  out  1  1 for LW/SW.
- rf_write_o  out  1  coprocessor RF write strobe.
- rf_rd_o  out  5  RF address.
- rf_data_o  out  DATA_W  RF data.
- clear_o  out  NB_ID  one-hot scoreboard clear pulses.
- kill_o  out  1  flush request to upstream pipeline.
- occupancy_o  out  $clog2(DEPTH)+1  valid entries.
- err_o  out  1  sticky: mem result with unmatched ID.

## Operation
- Entry fields: instr, id, rd, rs1, result, done, rdata. Circular buffer with head/tail pointers and a count.
- Enqueue when ex_valid_i & ex_ready_o & ex_instr_i≠INVALID. INVALID is consumed without allocating an entry.
- On enqueue, done=1 for DOTP and done=0 for LW/SW.
- ex_ready_o = (count<DEPTH) & ~kill_o. There is no same-cycle full bypass.
- Mem result: set done and store rdata in the oldest valid entry with id==mem_result_id_i and done=0. The incoming enqueue is included in the search and is treated as the youngest entry.
- If no entry matches, the result is dropped and err_o is set. err_o is cleared only by reset.
- head_done = head.done | (mem_result_valid_i & match on head). Mem rdata is bypassed to rf_data_o in that same cycle.
- result_valid_o = head valid & head_done & commit_i[head.id] & ~kill_o.
- Retire = result_valid_o & result_ready_i. In the retire cycle:
  - rf_write_o=1 for LW (data=rdata) or DOTP (data=result), with rf_rd_o=head.rd.
  - clear_o[head.id]=1.
  - head advances.
- SW retires with rf_write_o=0.
- result_* fields show the head whenever the head is valid, and are 0 otherwise.
- Kill:
  - kill_o = OR over valid entries of kill_i[entry.id].
  - At the next edge, the oldest killed entry and every younger entry are removed.
  - clear_o pulses for every removed ID in the kill cycle.
  - There is no retire and no rf_write in the kill cycle. Kill has priority over retire and mem match.

## Timing
- Reset values: result_valid_o=0, result_*=0, rf_write_o=0, rf_rd_o=0, rf_data_o=0, clear_o=0, kill_o=0, occupancy_o=0, err_o=0, ex_ready_o=1.
- Enqueue edge N: the entry is visible at N+1. Earliest result_valid_o is cycle N+1 (DOTP already committed, or LW with mem result in cycle N+1).
- result_valid_o stays high, with result_* held stable, until result_ready_i, unless a kill intervenes.
- Retire and enqueue in the same cycle: count unchanged, pointers both advance.
- Full queue: ex_ready_o=0 even in a retire cycle; it rises the cycle after retire.
- Pointers wrap modulo DEPTH.
- Mid-operation reset clears all entries and flags immediately (asynchronous).

## Test plan
- DOTP id=3 result=0x1234, commit_i[3] high, ready high -> result_valid_o at N+1, rf_write_o=1, rf_data_o=0x1234, clear_o=0x0008, occupancy 1→0.
- LW id=5 rd=7, mem rdata 0xCAFEBABE two cycles later, committed -> retire in the mem result cycle with rf_data_o=0xCAFEBABE, result_we_o=1, result_data_o=post-increment address.
- Four SWs ids 0..3, ex_valid_i held, result_ready_i=0 -> ex_ready_o=0 after 4 enqueues. One ready pulse -> one retire, ex_ready_o=1 the next cycle. Pointers wrap correctly over 10 instructions.
- Entries ids 1,2,3 with kill_i[2] -> kill_o=1 for one cycle, clear_o=0x000C, occupancy 3→1, no rf_write, id 1 still retires normally.
- mem_result_id_i=9 with no id 9 queued -> err_o=1 sticky, queue state unchanged.
- Commit withheld for 5 cycles with mem result already received -> result_valid_o=0 throughout, asserts the cycle commit_i rises; rdata taken from the stored entry.
